// File: rtl/sub_bytes_ced_pkg.sv
// Shared constants, state encoding, fault-injection payload and the
// parity predictor / syndrome checker used by the SubBytes CED datapath.
package sub_bytes_ced_pkg;

    localparam int unsigned CW_W    = 12;
    localparam int unsigned SYN_W   = 4;
    localparam int unsigned NBYTES  = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned STATE_W = NBYTES * BYTE_W;

    localparam logic [3:0] FI_NONE = 4'd12;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    typedef struct packed {
        logic       en;
        logic [3:0] byte_idx;
        logic [3:0] bit_idx;
    } fi_cfg_t;

    function automatic logic [3:0] predict(input logic [7:0] s);
        predict = {s[7] ^ s[6] ^ s[4] ^ s[3] ^ s[2],
                   s[7] ^ s[6] ^ s[5] ^ s[4] ^ s[2] ^ s[0],
                   s[7] ^ s[6] ^ s[5] ^ s[3] ^ s[1] ^ s[0],
                   s[7] ^ s[5] ^ s[4] ^ s[3] ^ s[1]};
    endfunction

    // Syndrome is reported with the w0 mismatch in the MSB.
    function automatic logic [SYN_W-1:0] check_syn(input logic [CW_W-1:0] cw);
        logic [3:0] d;
        d = predict(cw[11:4]) ^ cw[3:0];
        check_syn = {d[0], d[1], d[2], d[3]};
    endfunction

endpackage

// File: rtl/sub_bytes_ced_if.sv
// Block-level handshake bus: state in with fault-injection controls, result out with error report.
interface sub_bytes_ced_if;
    import sub_bytes_ced_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_state;
    logic               fi_en;
    logic [3:0]         fi_byte;
    logic [3:0]         fi_bit;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;
    logic               err;
    logic [3:0]         err_idx;
    logic [SYN_W-1:0]   err_syn;

    modport master (
        output in_valid, in_state, fi_en, fi_byte, fi_bit, out_ready,
        input  in_ready, out_valid, out_state, err, err_idx, err_syn
    );

    modport slave (
        input  in_valid, in_state, fi_en, fi_byte, fi_bit, out_ready,
        output in_ready, out_valid, out_state, err, err_idx, err_syn
    );
endinterface

// File: rtl/sub_bytes_ced_lane.sv
// Combinational byte lane: S-box, parity prediction, optional codeword flip, syndrome check.
module sub_bytes_ced_lane
    import sub_bytes_ced_pkg::*;
(
    input  logic [7:0]       din,
    input  logic [CW_W-1:0]  flip,
    output logic [7:0]       sb_out,
    output logic [3:0]       w,
    output logic [SYN_W-1:0] syn
);

    // Entry x sits at bits [(255-x)*8 +: 8].
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0]      sb_raw;
    logic [CW_W-1:0] cw;

    always_comb begin
        sb_raw = SBOX_TBL[(11'd255 - 11'(din)) * 11'd8 +: 8];
        cw     = {sb_raw, predict(sb_raw)} ^ flip;
        sb_out = cw[11:4];
        w      = cw[3:0];
        syn    = check_syn(cw);
    end

endmodule

// File: rtl/sub_bytes_ced_engine.sv
// Sequential SubBytes engine: one byte per cycle through a checked lane, first-error capture.
module sub_bytes_ced_engine
    import sub_bytes_ced_pkg::*;
#(
    parameter bit FI_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    sub_bytes_ced_if.slave bus
);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic [STATE_W-1:0] src_q;
    logic [STATE_W-1:0] res_q;
    fi_cfg_t            fi_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               err_q;
    logic [3:0]         err_idx_q;
    logic [SYN_W-1:0]   err_syn_q;

    logic [CW_W-1:0]    flip_c;
    logic [7:0]         lane_sb;
    logic [3:0]         unused_lane_w;
    logic [SYN_W-1:0]   lane_syn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and the fault-injection mask for the byte in flight.
    always_comb begin
        state_nxt = state;
        flip_c    = '0;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (cnt == 4'(NBYTES - 1)) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (FI_EN && (state == RUN) && fi_q.en && (cnt == fi_q.byte_idx)
                && (fi_q.bit_idx < FI_NONE))
            flip_c = CW_W'(1) << fi_q.bit_idx;
    end

    // Source bytes leave from the top; results enter at the bottom, so byte 0 ends up on top.
    sub_bytes_ced_lane u_lane (
        .din    (src_q[STATE_W-1 -: 8]),
        .flip   (flip_c),
        .sb_out (lane_sb),
        .w      (unused_lane_w),
        .syn    (lane_syn)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q       <= '0;
            res_q       <= '0;
            fi_q        <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_idx_q   <= '0;
            err_syn_q   <= '0;
        end else begin
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        src_q     <= bus.in_state;
                        fi_q      <= {bus.fi_en, bus.fi_byte, bus.fi_bit};
                        cnt       <= '0;
                        err_q     <= 1'b0;
                        err_idx_q <= '0;
                        err_syn_q <= '0;
                    end
                end
                RUN: begin
                    src_q <= {src_q[STATE_W-9:0], 8'h00};
                    res_q <= {res_q[STATE_W-9:0], lane_sb};
                    cnt   <= cnt + 4'd1;
                    if ((lane_syn != '0) && !err_q) begin
                        err_q     <= 1'b1;
                        err_idx_q <= cnt;
                        err_syn_q <= lane_syn;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = res_q;
    assign bus.err       = err_q;
    assign bus.err_idx   = err_idx_q;
    assign bus.err_syn   = err_syn_q;

endmodule
